apb_slave_regfile: RTL and testbench

APB completer that answers transfers from the team's APB master. It decodes word-aligned addresses into a bank of read/write registers, inserts a configurable number of wait states, and signals PSLVERR for illegal accesses. It sits on the peripheral side of the APB link and drives `pready`, `prdata` and `pslverr` back to the master.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_slv_regbank.sv | 28 ++
 rtl/apb_slave_regfile.sv | 140 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 126 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM states, word-offset constant, default widths.
package apb_pkg;
  localparam int APB_ADDR_W   = 32;
  localparam int APB_DATA_W   = 32;
  localparam int APB_WORD_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } apb_slv_state_t;
endpackage

// File: rtl/apb_slv_regbank.sv
// Register array for the APB slave: one indexed write port, one combinational read port.
module apb_slv_regbank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[widx] = wdata;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  assign rdata = regs_q[ridx];
endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a register bank, decode and PSLVERR on illegal access.
// Optional wait states are compiled in with `APB_SLV_WAIT_EN.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  localparam int IDX_W = $clog2(NUM_REGS);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || NUM_REGS < 2) begin : g_bad_cfg
    $error("apb_slave_regfile: WAIT_CYCLES must be 0..15 and NUM_REGS >= 2");
  end

  apb_slv_state_t    state_q, state_d;
  logic              legal_q, legal_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              go_done, we;
  logic              dec_legal;
  logic [IDX_W-1:0]  dec_idx;
  logic [DATA_W-1:0] rdata;
`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`endif

  assign dec_legal = (paddr[1:0] == 2'b00) && (paddr < ADDR_W'(NUM_REGS * 4));
  assign dec_idx   = paddr[APB_WORD_LSB +: IDX_W];

  always_comb begin
    state_d   = state_q;
    legal_d   = legal_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    go_done   = 1'b0;
    we        = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (psel && !penable) begin
        legal_d = dec_legal;
        idx_d   = dec_idx;
        wr_d    = pwrite;
`ifdef APB_SLV_WAIT_EN
        if (WAIT_N == 4'd0) begin
          state_d = DONE;
          go_done = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_N - 4'd1;
        end
`else
        state_d = DONE;
        go_done = 1'b1;
`endif
      end
`ifdef APB_SLV_WAIT_EN
      WAIT: begin
        if (!psel) state_d = IDLE;
        else if (cnt_q == 4'd0) begin
          state_d = DONE;
          go_done = 1'b1;
        end else cnt_d = cnt_q - 4'd1;
      end
`endif
      DONE: begin
        we      = legal_q && wr_q && psel && penable && pwrite;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they load on the edge that enters DONE.
    if (go_done) begin
      pready_d  = 1'b1;
      pslverr_d = !legal_d;
      prdata_d  = (legal_d && !wr_d) ? rdata : '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      legal_q   <= 1'b0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      legal_q   <= legal_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  apb_slv_regbank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regbank (
    .pclk    (pclk),
    .presetn (presetn),
    .we      (we),
    .widx    (idx_q),
    .wdata   (pwdata),
    .ridx    (idx_d),
    .rdata   (rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile; latency expectations follow `APB_SLV_WAIT_EN.
module tb_apb_slave_regfile;
  import apb_pkg::*;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int errors = 0;
  int checks = 0;

  apb_slave_regfile #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(2)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase with the bus idle.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 1;
    while (!pready && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(EXP_LAT));
    chk({tag, "_err"}, {31'd0, pslverr}, {31'd0, exp_err});
    chk({tag, "_rd"}, prdata, exp_rd);
    @(posedge pclk); #1;
    chk({tag, "_rdy_drop"}, {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    xfer("rd04_rst", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
    xfer("wr08", 1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("rd08", 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);

    xfer("wr40_oob", 1'b1, 32'h40, 32'h12345678, 32'h0, 1'b1);
    xfer("wr06_mis", 1'b1, 32'h06, 32'h12345678, 32'h0, 1'b1);
    xfer("rd0a_mis", 1'b0, 32'h0A, 32'h0, 32'h0, 1'b1);
    xfer("rd00_clean", 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    xfer("rd04_clean", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
    xfer("rd08_keep", 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);

    // Back-to-back: each call starts its setup in the cycle the slave returns to IDLE.
    xfer("b2b_wr0c", 1'b1, 32'h0C, 32'h1, 32'h0, 1'b0);
    xfer("b2b_wr10", 1'b1, 32'h10, 32'h2, 32'h0, 1'b0);
    xfer("b2b_wr3c", 1'b1, 32'h3C, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer("b2b_rd0c", 1'b0, 32'h0C, 32'h0, 32'h1, 1'b0);
    xfer("b2b_rd10", 1'b0, 32'h10, 32'h0, 32'h2, 1'b0);
    xfer("b2b_rd3c", 1'b0, 32'h3C, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef APB_SLV_WAIT_EN
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55AA55AA;
    @(posedge pclk); #1;
    chk("abort_rdy_t1", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_rdy_t2", {31'd0, pready}, 32'd0);
    chk("abort_idle", 32'(dut.state_q), 32'(IDLE));
    @(posedge pclk); #1;
    chk("abort_rdy_t3", {31'd0, pready}, 32'd0);
    xfer("abort_rd04", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
`endif

    // Reset lands in the enable phase, before the edge that would commit the write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'hA5A5A5A5;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, pready}, 32'd0);
    chk("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("midrst_prdata", prdata, 32'd0);
    chk("midrst_idle", 32'(dut.state_q), 32'(IDLE));
    psel = 1'b0; penable = 1'b0;
    #2 presetn = 1'b1;
    @(posedge pclk); #1;
    xfer("midrst_rd00", 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    xfer("midrst_rd08", 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
